context_save_restore: RTL
=========================

Name: context_save_restore

Overview:
- Sequencer that moves a whole process register set between the register bank and data memory on a context switch.
- Save: walks register addresses 0..NUM_REGS-1, reads each word through the bank's asynchronous read port and writes it to a per-process memory slot.
- Restore: reads the slot back from synchronous data memory and writes each word into the bank through its write port.
- Sits beside the control unit. The control unit pulses start during context-switch opcodes and stalls the pipeline while busy is high.

Parameters:
- NUM_REGS, 32, registers per context; also the slot stride in words.
- ADDR_W, 10, data-memory word-address width.
- BASE_ADDR, 10'd512, word address of process 0's slot.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- modo  input  1  0 = save (bank -> memory), 1 = restore (memory -> bank); latched at start
- indiceProcesso  input  4  process whose slot is used; latched at start
- busy  output  1  high while a transfer is in progress, including the DONE cycle
- done  output  1  one-cycle completion pulse
- regEndereco  output  5  register address presented to the bank read/write port
- regDado  input  32  bank read data; combinational from regEndereco
- regEscrita  output  1  bank write strobe
- regDadoEscrita  output  32  bank write data
- memEndereco  output  ADDR_W  data-memory word address
- memEscrita  output  1  memory write strobe
- memLeitura  output  1  memory read strobe
- memDadoEscrita  output  32  memory write data
- memDadoLeitura  input  32  memory read data; valid the cycle after memLeitura

Behaviour:
- Reset values: busy=0, done=0, regEscrita=0, memEscrita=0, memLeitura=0, regEndereco=0, memEndereco=0, regDadoEscrita=0. State is IDLE and all counters are 0.
- Reset mid-transfer: return to IDLE on the next edge and drop all strobes. No done pulse. The partially written slot or bank is left as-is.
- Slot base: base = BASE_ADDR + indiceProcesso_latched*NUM_REGS, computed at ADDR_W width (wraps modulo 2^ADDR_W). Word i goes to base+i.
- States: IDLE, SAVE, RESTORE, DRAIN, DONE.
- IDLE:
  - start=1 latches modo and indiceProcesso and clears idx.
  - Next state is SAVE if modo=0, RESTORE if modo=1.
  - start=0 stays in IDLE.
- SAVE, one word per cycle:
  - regEndereco=idx, memEndereco=base+idx, memDadoEscrita=regDado, memEscrita=1.
  - idx increments each cycle.
  - After idx=NUM_REGS-1, go to DONE.
  - Register 0 is saved like any other register.
- RESTORE:
  - memLeitura=1, memEndereco=base+idx, idx increments each cycle.
  - One cycle later the returning word is written: regEndereco=idx_d (idx delayed one cycle), regDadoEscrita=memDadoLeitura, regEscrita=1.
  - The write for idx_d=0 is suppressed (regEscrita=0); register 0 stays hardwired to zero.
  - After issuing idx=NUM_REGS-1, go to DRAIN.
- DRAIN: no read issued; performs the final register write for NUM_REGS-1, then goes to DONE.
- DONE: done=1 for exactly one cycle, strobes low, then IDLE.
- Timing, with start accepted at edge N:
  - Save: memEscrita high cycles N+1..N+32, done at N+33.
  - Restore: memLeitura high N+1..N+32, regEscrita high N+3..N+33, done at N+34.
  - busy is high from N+1 through the done cycle inclusive.
- start while busy, including in DONE, is ignored and not queued.
- Outside active cycles, strobes are 0. Address and data outputs hold their last values and are don't-care.
- memEscrita and memLeitura are never high in the same cycle. regEscrita is never high during a save.

Optional Feature:
- Macro CONTEXT_CHECKSUM_EN.
- When defined, add output checksum [31:0]:
  - cleared to 0 on reset and when start is accepted;
  - XOR-accumulates every word transferred (regDado in save, memDadoLeitura in restore, including word 0);
  - stable from the done cycle until the next accepted start.
- When undefined, the port and its logic do not exist.

Test Plan:
- Save: reg i preloaded with 32'hA000_0000+i, indiceProcesso=2, start at edge N -> memEscrita for 32 consecutive cycles at addresses 576..607 with data A000_0000..A000_001F; done at N+33, busy high N+1..N+33.
- Restore: memory 576+i = 32'h5A00_0000+i, modo=1, indiceProcesso=2 -> regEscrita at N+3..N+33 for regs 1..31 with matching data; reg 0 never written; done at N+34.
- Wrap: indiceProcesso=15 with BASE_ADDR=1000 -> base = 1480 mod 1024 = 456; addresses 456..487.
- Start at N+5 and at the DONE cycle of a save -> ignored; exactly one done; returns to IDLE.
- Reset asserted at N+10 of a restore -> next cycle all strobes 0, busy 0, no done; a new start afterwards completes normally.
- With CONTEXT_CHECKSUM_EN: save of regs i = i -> checksum = XOR of 0..31 = 0. Save of i = 1<<i -> checksum = 32'hFFFF_FFFF.

Source files
------------

// File: rtl/context_save_restore.sv
// Register-set save/restore sequencer: bank <-> per-process memory slot.
// Optional CONTEXT_CHECKSUM_EN adds an XOR checksum of transferred words.
module context_save_restore #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 10'd512
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              modo,
  input  logic [3:0]        indiceProcesso,
  output logic              busy,
  output logic              done,
  output logic [4:0]        regEndereco,
  input  logic [31:0]       regDado,
  output logic              regEscrita,
  output logic [31:0]       regDadoEscrita,
  output logic [ADDR_W-1:0] memEndereco,
  output logic              memEscrita,
  output logic              memLeitura,
  output logic [31:0]       memDadoEscrita,
  input  logic [31:0]       memDadoLeitura
`ifdef CONTEXT_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RESTORE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_d;
  logic              pend;
  logic [3:0]        proc_q;
  logic [ADDR_W-1:0] base;

  assign base = BASE_ADDR
              + ADDR_W'(proc_q) * ADDR_W'(NUM_REGS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      idx_d  <= '0;
      pend   <= 1'b0;
      proc_q <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            pend   <= 1'b0;
            proc_q <= indiceProcesso;
          end
        end
        S_SAVE: idx <= idx + IW'(1);
        S_RESTORE: begin
          idx   <= idx + IW'(1);
          idx_d <= idx;
          pend  <= 1'b1;
        end
        S_DRAIN: pend <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n        = state;
    busy           = 1'b0;
    done           = 1'b0;
    regEndereco    = '0;
    regEscrita     = 1'b0;
    regDadoEscrita = '0;
    memEndereco    = '0;
    memEscrita     = 1'b0;
    memLeitura     = 1'b0;
    memDadoEscrita = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = modo ? S_RESTORE : S_SAVE;
      end
      S_SAVE: begin
        busy           = 1'b1;
        regEndereco    = 5'(idx);
        memEndereco    = base + ADDR_W'(idx);
        memDadoEscrita = regDado;
        memEscrita     = 1'b1;
        if (idx == LAST) state_n = S_DONE;
      end
      S_RESTORE: begin
        busy        = 1'b1;
        memLeitura  = 1'b1;
        memEndereco = base + ADDR_W'(idx);
        if (idx == LAST) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Word read last cycle lands in the bank now; r0 stays zero
    if (pend) begin
      regEndereco    = 5'(idx_d);
      regDadoEscrita = memDadoLeitura;
      regEscrita     = (idx_d != '0);
    end
  end

`ifdef CONTEXT_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (memEscrita) begin
      checksum <= checksum ^ regDado;
    end else if (pend) begin
      checksum <= checksum ^ memDadoLeitura;
    end
  end
`endif

endmodule
